pe_result_collector: RTL and testbench
======================================

# pe_result_collector

Collects the per-PE 8-bit results that the systolic PE block emits in skewed form, one lane at a time, and assembles them into complete frames of ARRAY_NUM*BLOCK_NUM bytes. Completed frames are buffered in a small frame FIFO and drained byte-serially over a valid/ready stream toward the output writer. It sits directly downstream of the PE block and consumes its result and result-valid buses unmodified.

## Interface
- ARRAY_NUM, 3, PEs per array; must match the PE block.
- BLOCK_NUM, 3, arrays per block; must match the PE block. N = ARRAY_NUM*BLOCK_NUM lanes.
- DEPTH, 4, frame FIFO depth in frames; power of two, ≥2.

Clock and reset: one clock; reset is asynchronous and active-high. Ports:
- iClk  in  1  clock.
- iRst  in  1  asynchronous active-high reset.
- iFlush  in  1  synchronous; discards the partial frame and all buffered frames.
- iResult  in  8*N  PE results; lane k is bits [8k+7:8k].
- iResultValid  in  N  per-lane valid strobes, one cycle each.
- oData  out  8  output byte.
- oValid  out  1  oData valid.
- iReady  in  1  downstream accepts oData this cycle.
- oLast  out  1  oData is the last byte (lane N-1) of a frame.
- oFrameCount  out  $clog2(DEPTH+1)  frames currently buffered.
- oOverflow  out  1  sticky: a frame was dropped on a full FIFO.
- oLaneError  out  1  sticky: a lane strobed twice within one frame.

## Operation
- Capture: each lane has a byte register and a captured flag. When iResultValid[k]=1, lane k's byte is latched and its flag is set.
- Frame completion:
  - complete = &(flags | iResultValid).
  - On the completing edge, the frame is written to the FIFO. Incoming bytes bypass into the entry. All flags clear.
- Duplicate strobe: iResultValid[k]=1 while flag[k] is already set.
  - The new byte overwrites the old one.
  - oLaneError sets.
- Full FIFO on completion: oFrameCount==DEPTH and no pop in the same cycle.
  - The frame is dropped and oOverflow sets.
  - Flags still clear.
  - If a pop occurs in the same cycle, the push is accepted.
- Drain:
  - oValid = (oFrameCount!=0).
  - oData is byte[idx] of the head frame, where idx is a byte counter 0..N-1, lane 0 first.
  - oLast = oValid && idx==N-1.
  - A handshake (oValid&&iReady) increments idx. At idx==N-1 the handshake pops the head frame and idx wraps to 0.
- oData, oLast and oValid stay stable while oValid&&!iReady.
- oFrameCount = pushes − pops. Simultaneous push and pop leaves it unchanged.
- iFlush (priority over capture, push and pop):
  - clears flags, FIFO pointers, oFrameCount and idx.
  - does not clear the sticky flags.
  - strobes arriving in the flush cycle are ignored.
- Sticky flags clear only on iRst.

## Timing
- Reset values:
  - oValid=0, oLast=0, oData=0, oFrameCount=0, oOverflow=0, oLaneError=0.
  - Internal state: flags=0, idx=0, FIFO pointers=0.
- Latency: last lane strobe in cycle t → oValid=1 with lane-0 byte in cycle t+1 (FIFO previously empty).
- Throughput: one byte per cycle with iReady held high. A frame drains in N cycles. Back-to-back frames stream with no bubble.
- oOverflow and oLaneError assert in the cycle after the offending edge.
- iRst asserted mid-frame or mid-drain: all state returns to reset values immediately, without waiting for a clock edge. Operation resumes on the first edge after deassertion.
- Wrap-around: FIFO pointers carry one extra bit to distinguish full from empty. idx wraps N-1→0 only on a handshake.

## Test plan
- Skewed fill, N=9: lanes 0..8 strobe on consecutive cycles with bytes 0x10..0x18, iReady=1 → from the cycle after lane 8: oData 0x10..0x18 on consecutive cycles, oLast only on 0x18, oFrameCount returns to 0.
- Backpressure: one frame buffered, iReady low for 5 cycles after byte 3 → oData holds byte 3 with oValid=1; draining resumes in order; no bytes lost.
- Overflow, DEPTH=4, iReady=0: push 5 frames → oFrameCount=4, oOverflow=1. Then drain with iReady=1 → exactly frames 1..4, then oValid=0.
- Full plus simultaneous pop: FIFO full, a frame completes on the same edge as the last-byte handshake → frame accepted, oFrameCount stays 4, oOverflow stays 0.
- Duplicate strobe: lane 2 strobes 0xAA then 0xBB before the frame completes → frame carries 0xBB in lane 2, oLaneError=1.
- Flush and reset: 2 frames buffered plus a partial frame → iFlush gives oFrameCount=0, oValid=0 next cycle, sticky flags kept. iRst asserted mid-drain → all outputs 0 without a clock edge.

Source files
------------

// File: rtl/pe_result_collector.sv
// pe_result_collector
// Gathers skewed per-lane PE result bytes into complete frames, buffers the
// frames in a small FIFO and streams them out one byte per handshake.
module pe_result_collector #(
  parameter int ARRAY_NUM = 3,
  parameter int BLOCK_NUM = 3,
  parameter int DEPTH     = 4
) (
  input  logic                                 iClk,
  input  logic                                 iRst,
  input  logic                                 iFlush,
  input  logic [8*ARRAY_NUM*BLOCK_NUM-1:0]     iResult,
  input  logic [ARRAY_NUM*BLOCK_NUM-1:0]       iResultValid,
  output logic [7:0]                           oData,
  output logic                                 oValid,
  input  logic                                 iReady,
  output logic                                 oLast,
  output logic [$clog2(DEPTH+1)-1:0]           oFrameCount,
  output logic                                 oOverflow,
  output logic                                 oLaneError
);

  localparam int N  = ARRAY_NUM * BLOCK_NUM;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef logic [N-1:0][7:0] frame_t;

  // Capture state for the frame being assembled
  frame_t          lane_q, lane_d;
  logic [N-1:0]    flags_q, flags_d;

  // Frame FIFO; pointers carry one extra bit so full and empty differ
  frame_t          mem_q [DEPTH];
  frame_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;

  // Byte counter within the head frame and the sticky status bits
  logic [IW-1:0]   idx_q, idx_d;
  logic            ovf_q, ovf_d;
  logic            lerr_q, lerr_d;

  logic [PW-1:0]   count_s;
  logic            valid_s;
  logic            full_s;
  logic            hs_s;
  logic            pop_s;
  logic            complete_s;
  logic            push_s;
  logic            drop_s;
  logic            dup_s;
  logic [N-1:0]    seen_s;
  frame_t          entry_s;
  frame_t          head_s;

  // Handshake, completion and FIFO status decode
  always_comb begin
    count_s    = wr_ptr_q - rd_ptr_q;
    valid_s    = (count_s != {PW{1'b0}});
    full_s     = (count_s == PW'(DEPTH));
    hs_s       = valid_s && iReady;
    pop_s      = hs_s && (idx_q == LAST_IDX);
    seen_s     = flags_q | iResultValid;
    complete_s = &seen_s;
    push_s     = complete_s && (!full_s || pop_s);
    drop_s     = complete_s && full_s && !pop_s;
    dup_s      = |(iResultValid & flags_q);
    // Bytes strobed on the completing edge go straight into the FIFO entry
    entry_s    = lane_q;
    for (int k = 0; k < N; k++) begin
      if (iResultValid[k]) begin
        entry_s[k] = iResult[8*k +: 8];
      end else begin
        entry_s[k] = lane_q[k];
      end
    end
  end

  // Next-state for capture, FIFO pointers, byte counter and sticky flags
  always_comb begin
    lane_d   = lane_q;
    flags_d  = flags_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    idx_d    = idx_q;
    ovf_d    = ovf_q;
    lerr_d   = lerr_q;
    if (iFlush) begin
      // Flush drops everything in flight but keeps the sticky history
      flags_d  = {N{1'b0}};
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      idx_d    = {IW{1'b0}};
    end else begin
      lane_d = entry_s;
      if (complete_s) begin
        flags_d = {N{1'b0}};
      end else begin
        flags_d = seen_s;
      end
      if (push_s) begin
        mem_d[wr_ptr_q[AW-1:0]] = entry_s;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (hs_s) begin
        if (idx_q == LAST_IDX) begin
          idx_d = {IW{1'b0}};
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end else begin
        idx_d = idx_q;
      end
      if (drop_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
      if (dup_s) begin
        lerr_d = 1'b1;
      end else begin
        lerr_d = lerr_q;
      end
    end
  end

  // Control state registers with asynchronous reset
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      lane_q   <= '0;
      flags_q  <= {N{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      idx_q    <= {IW{1'b0}};
      ovf_q    <= 1'b0;
      lerr_q   <= 1'b0;
    end else begin
      lane_q   <= lane_d;
      flags_q  <= flags_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      idx_q    <= idx_d;
      ovf_q    <= ovf_d;
      lerr_q   <= lerr_d;
    end
  end

  // Frame storage; contents are only observed through valid pointers, so no reset
  always_ff @(posedge iClk) begin
    mem_q <= mem_d;
  end

  // Output stream: head frame byte selected by the byte counter, zero when idle
  always_comb begin
    head_s = mem_q[rd_ptr_q[AW-1:0]];
    if (valid_s) begin
      oData = head_s[idx_q];
    end else begin
      oData = 8'h00;
    end
    oValid      = valid_s;
    oLast       = valid_s && (idx_q == LAST_IDX);
    oFrameCount = CW'(count_s);
    oOverflow   = ovf_q;
    oLaneError  = lerr_q;
  end

endmodule

// File: tb/tb_pe_result_collector.sv
// tb_pe_result_collector
// Randomized and directed stimulus against a queue-based frame model.
module tb_pe_result_collector;

  localparam int ARRAY_NUM = 3;
  localparam int BLOCK_NUM = 3;
  localparam int DEPTH     = 4;
  localparam int N         = ARRAY_NUM * BLOCK_NUM;
  localparam int CW        = $clog2(DEPTH + 1);

  typedef logic [N-1:0][7:0] frame_t;

  logic                 clk = 1'b0;
  logic                 iRst = 1'b1;
  logic                 iFlush = 1'b0;
  logic [8*N-1:0]       iResult = '0;
  logic [N-1:0]         iResultValid = '0;
  logic                 iReady = 1'b0;
  logic [7:0]           oData;
  logic                 oValid;
  logic                 oLast;
  logic [CW-1:0]        oFrameCount;
  logic                 oOverflow;
  logic                 oLaneError;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  frame_t       mq[$];
  frame_t       m_part;
  logic [N-1:0] m_flags;
  int           m_idx;
  bit           m_ovf;
  bit           m_lerr;

  pe_result_collector #(.ARRAY_NUM(ARRAY_NUM), .BLOCK_NUM(BLOCK_NUM), .DEPTH(DEPTH)) dut (
    .iClk(clk), .iRst(iRst), .iFlush(iFlush), .iResult(iResult),
    .iResultValid(iResultValid), .oData(oData), .oValid(oValid), .iReady(iReady),
    .oLast(oLast), .oFrameCount(oFrameCount), .oOverflow(oOverflow), .oLaneError(oLaneError)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8*N-1:0] one_lane(input int k, input logic [7:0] v);
    logic [8*N-1:0] r;
    r = '0;
    r[8*k +: 8] = v;
    return r;
  endfunction

  function automatic logic [8*N-1:0] fill_frame(input logic [7:0] v);
    logic [8*N-1:0] r;
    for (int k = 0; k < N; k++) r[8*k +: 8] = v;
    return r;
  endfunction

  // One clock edge of the behavioural frame collector
  task automatic model_step(input logic fl, input logic [N-1:0] rv,
                            input logic [8*N-1:0] res, input logic rdy);
    int sz;
    bit hs;
    bit pop;
    if (fl) begin
      mq.delete();
      m_flags = '0;
      m_idx = 0;
    end else begin
      sz  = mq.size();
      hs  = (sz != 0) && rdy;
      pop = hs && (m_idx == N - 1);
      if ((rv & m_flags) != '0) m_lerr = 1'b1;
      for (int k = 0; k < N; k++) if (rv[k]) m_part[k] = res[8*k +: 8];
      m_flags = m_flags | rv;
      if (hs) begin
        if (pop) begin
          void'(mq.pop_front());
          m_idx = 0;
        end else begin
          m_idx++;
        end
      end
      if (&m_flags) begin
        if (sz == DEPTH && !pop) m_ovf = 1'b1;
        else mq.push_back(m_part);
        m_flags = '0;
      end
    end
  endtask

  task automatic check_outputs();
    bit ev;
    ev = (mq.size() != 0);
    check("valid", oValid, ev);
    check("data", oData, ev ? mq[0][m_idx] : 8'h00);
    check("last", oLast, ev && (m_idx == N - 1));
    check("count", oFrameCount, mq.size());
    check("overflow", oOverflow, m_ovf);
    check("lane_error", oLaneError, m_lerr);
  endtask

  // Drive one cycle's inputs from a negedge, advance, and check at the next negedge
  task automatic step(input logic fl, input logic [N-1:0] rv,
                      input logic [8*N-1:0] res, input logic rdy);
    iFlush = fl;
    iResultValid = rv;
    iResult = res;
    iReady = rdy;
    model_step(fl, rv, res, rdy);
    @(posedge clk);
    @(negedge clk);
    iResultValid = '0;
    iFlush = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int cycles, input logic rdy);
    for (int i = 0; i < cycles; i++) step(1'b0, '0, '0, rdy);
  endtask

  // Raise reset between edges and confirm outputs clear before any edge
  task automatic do_reset();
    @(negedge clk);
    #2;
    iRst = 1'b1;
    #1;
    check("rst_valid", oValid, 1'b0);
    check("rst_data", oData, 8'h00);
    check("rst_last", oLast, 1'b0);
    check("rst_count", oFrameCount, 0);
    check("rst_overflow", oOverflow, 1'b0);
    check("rst_lane_error", oLaneError, 1'b0);
    mq.delete();
    m_flags = '0;
    m_idx = 0;
    m_ovf = 1'b0;
    m_lerr = 1'b0;
    iFlush = 1'b0;
    iResultValid = '0;
    iReady = 1'b0;
    @(negedge clk);
    iRst = 1'b0;
  endtask

  initial begin
    logic [8*N-1:0] f;
    logic [N-1:0]   rv;
    m_part = '0;
    m_flags = '0;
    m_idx = 0;
    m_ovf = 1'b0;
    m_lerr = 1'b0;
    #2;
    check("init_valid", oValid, 1'b0);
    check("init_count", oFrameCount, 0);
    do_reset();

    // Skewed fill with bytes 0x10..0x18, drained with ready high
    for (int k = 0; k < N; k++) step(1'b0, N'(1) << k, one_lane(k, 8'(8'h10 + k)), 1'b1);
    check("skew_first", oData, 8'h10);
    check("skew_first_valid", oValid, 1'b1);
    for (int j = 1; j < N; j++) begin
      step(1'b0, '0, '0, 1'b1);
      check("skew_byte", oData, 8'h10 + j);
      check("skew_last", oLast, (j == N - 1));
    end
    step(1'b0, '0, '0, 1'b1);
    check("skew_empty", oFrameCount, 0);

    // Backpressure after byte 3
    f = {$urandom, $urandom, $urandom};
    step(1'b0, '1, f, 1'b0);
    idle(3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, '0, 1'b0);
      check("bp_hold", oData, f[8*3 +: 8]);
      check("bp_valid", oValid, 1'b1);
    end
    idle(N - 3, 1'b1);
    check("bp_drained", oValid, 1'b0);

    // Overflow: five frames into a four-deep FIFO
    do_reset();
    for (int fr = 1; fr <= 5; fr++) step(1'b0, '1, fill_frame(8'(fr)), 1'b0);
    check("ovf_count", oFrameCount, DEPTH);
    check("ovf_flag", oOverflow, 1'b1);
    for (int fr = 1; fr <= DEPTH; fr++) begin
      for (int b = 0; b < N; b++) begin
        check("ovf_drain", oData, fr);
        step(1'b0, '0, '0, 1'b1);
      end
    end
    check("ovf_after", oValid, 1'b0);

    // Full FIFO with completion on the same edge as the popping handshake
    do_reset();
    for (int fr = 1; fr <= DEPTH; fr++) step(1'b0, '1, fill_frame(8'(fr)), 1'b0);
    idle(N - 1, 1'b1);
    step(1'b0, '1, fill_frame(8'h77), 1'b1);
    check("fullpop_count", oFrameCount, DEPTH);
    check("fullpop_ovf", oOverflow, 1'b0);
    idle(DEPTH * N, 1'b1);
    check("fullpop_empty", oValid, 1'b0);

    // Duplicate strobe on lane 2
    step(1'b0, N'(1) << 2, one_lane(2, 8'hAA), 1'b0);
    step(1'b0, N'(1) << 2, one_lane(2, 8'hBB), 1'b0);
    step(1'b0, ~(N'(1) << 2), fill_frame(8'h50), 1'b0);
    check("dup_err", oLaneError, 1'b1);
    idle(2, 1'b1);
    check("dup_byte", oData, 8'hBB);
    idle(N - 2, 1'b1);

    // Flush with two buffered frames and a partial one
    step(1'b0, '1, fill_frame(8'h21), 1'b0);
    step(1'b0, '1, fill_frame(8'h22), 1'b0);
    step(1'b0, 9'h00F, fill_frame(8'h23), 1'b0);
    step(1'b1, '1, fill_frame(8'h24), 1'b1);
    check("flush_count", oFrameCount, 0);
    check("flush_valid", oValid, 1'b0);
    check("flush_sticky", oLaneError, 1'b1);
    step(1'b0, 9'h1F0, fill_frame(8'h25), 1'b1);
    check("flush_partial_gone", oFrameCount, 0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rv = N'($urandom & $urandom);
      step(($urandom_range(0, 199) == 0), rv, {$urandom, $urandom, $urandom},
           ((i / 150) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of a drain
    idle(2 * N, 1'b0);
    step(1'b0, '1, fill_frame(8'h3C), 1'b0);
    idle(3, 1'b1);
    do_reset();
    step(1'b0, '1, fill_frame(8'h5A), 1'b0);
    check("post_rst_data", oData, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
